// File: rtl/rob_tid_issuer_if.sv
// ----------------------------------------------------------------------------
// rob_tid_issuer_if
// Handshake bundle between the AXI read-address source, the tID issuer and
// the tag-compare stage.
//   ar_*  : upstream read-address channel (valid/ready, id, addr)
//   req_* : stamped request to tag compare (valid/ready, tid, addr)
// Modports:
//   slave  : the issuer side (consumes ar_*, produces req_*)
//   master : the environment side (drives ar_*, accepts req_*)
// ----------------------------------------------------------------------------
interface rob_tid_issuer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int TID_WIDTH  = 4
);
    logic                  ar_valid_i;
    logic                  ar_ready_o;
    logic [ID_WIDTH-1:0]   ar_id_i;
    logic [ADDR_WIDTH-1:0] ar_addr_i;

    logic                  req_valid_o;
    logic                  req_ready_i;
    logic [TID_WIDTH-1:0]  req_tid_o;
    logic [ADDR_WIDTH-1:0] req_addr_o;

    modport slave (
        input  ar_valid_i,
        output ar_ready_o,
        input  ar_id_i,
        input  ar_addr_i,
        output req_valid_o,
        input  req_ready_i,
        output req_tid_o,
        output req_addr_o
    );

    modport master (
        output ar_valid_i,
        input  ar_ready_o,
        output ar_id_i,
        output ar_addr_i,
        input  req_valid_o,
        output req_ready_i,
        input  req_tid_o,
        input  req_addr_o
    );
endinterface

// File: rtl/rob_tid_issuer.sv
// ----------------------------------------------------------------------------
// rob_tid_issuer
// Front end of the reorder buffer. Stamps every accepted AXI read-address
// request with a sequential tID (same sequence as the ROB retirement
// counter), forwards it to tag compare, remembers the AXI ID per tID for the
// ROB's rid lookup, and caps the number of issued-but-unretired requests.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     ar_* request intake, req_* stamped request output
//   retire_i        one pulse per ROB retirement
//   lookup_tid_i    tID to translate back to an AXI ID
//   lookup_id_o     combinational ID table read
//   outstanding_o   issued-unretired count
//   idle_o          no request held and nothing outstanding
//   err_o           sticky: retire seen with nothing outstanding
//
// State  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no stamped request held
// S_HOLD | req_valid_o high; req_tid_o/req_addr_o frozen until req_ready_i
// ----------------------------------------------------------------------------
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef FIFO_SIZE
`define FIFO_SIZE 4
`endif

module rob_tid_issuer #(
    parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH        = `AXI_ID_WIDTH,
    parameter int TID_WIDTH       = `TID_WIDTH,
    parameter int MAX_OUTSTANDING = `FIFO_SIZE,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rob_tid_issuer_if.slave       bus,
    input  logic                  retire_i,
    input  logic [TID_WIDTH-1:0]  lookup_tid_i,
    output logic [ID_WIDTH-1:0]   lookup_id_o,
    output logic [OUT_W-1:0]      outstanding_o,
    output logic                  idle_o,
    output logic                  err_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int                TBL_DEPTH = 2 ** TID_WIDTH;
    localparam logic [OUT_W-1:0]  MAX_CNT   = OUT_W'(MAX_OUTSTANDING);

    state_t                  state, state_n;
    logic [TID_WIDTH-1:0]    next_tid;
    logic [OUT_W-1:0]        outstanding;
    logic [TID_WIDTH-1:0]    req_tid;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    err;
    logic [ID_WIDTH-1:0]     id_table [TBL_DEPTH];

    logic                    ar_ready;
    logic                    accept;
    logic                    retire_ok;

    // Ready looks only at the registered count, so a retire at the limit
    // frees a slot one cycle later rather than through a comb path.
    assign ar_ready  = (outstanding < MAX_CNT) &&
                       ((state == S_IDLE) || bus.req_ready_i);
    assign accept    = bus.ar_valid_i && ar_ready;
    assign retire_ok = retire_i && (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.req_ready_i && !accept) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // tID 1 first, to line up with the ROB's retirement counter after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_tid <= TID_WIDTH'(1);
            req_tid  <= '0;
            req_addr <= '0;
        end else if (accept) begin
            next_tid <= next_tid + TID_WIDTH'(1);
            req_tid  <= next_tid;
            req_addr <= bus.ar_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                id_table[i] <= '0;
            end
        end else if (accept) begin
            id_table[next_tid] <= bus.ar_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (accept && !retire_ok) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!accept && retire_ok) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (retire_i && (outstanding == '0)) begin
            err <= 1'b1;
        end
    end

    assign bus.ar_ready_o  = ar_ready;
    assign bus.req_valid_o = (state == S_HOLD);
    assign bus.req_tid_o   = req_tid;
    assign bus.req_addr_o  = req_addr;

    assign lookup_id_o     = id_table[lookup_tid_i];
    assign outstanding_o   = outstanding;
    assign idle_o          = (state == S_IDLE) && (outstanding == '0);
    assign err_o           = err;

endmodule

// File: tb/tb_rob_tid_issuer.sv
// ----------------------------------------------------------------------------
// tb_rob_tid_issuer
// Directed bench for rob_tid_issuer with TID_WIDTH=4, MAX_OUTSTANDING=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, well clear of the next active edge.
// ----------------------------------------------------------------------------
module tb_rob_tid_issuer;

    localparam int ADDR_WIDTH      = 16;
    localparam int ID_WIDTH        = 4;
    localparam int TID_WIDTH       = 4;
    localparam int MAX_OUTSTANDING = 4;
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1);

    logic                 clk;
    logic                 rst_n;
    logic                 retire_i;
    logic [TID_WIDTH-1:0] lookup_tid_i;
    logic [ID_WIDTH-1:0]  lookup_id_o;
    logic [OUT_W-1:0]     outstanding_o;
    logic                 idle_o;
    logic                 err_o;

    int n_assert = 0;
    int n_fail   = 0;

    rob_tid_issuer_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .TID_WIDTH  (TID_WIDTH)
    ) bus ();

    rob_tid_issuer #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .ID_WIDTH        (ID_WIDTH),
        .TID_WIDTH       (TID_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .retire_i      (retire_i),
        .lookup_tid_i  (lookup_tid_i),
        .lookup_id_o   (lookup_id_o),
        .outstanding_o (outstanding_o),
        .idle_o        (idle_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.ar_valid_i   = 1'b0;
        bus.ar_id_i      = '0;
        bus.ar_addr_i    = '0;
        bus.req_ready_i  = 1'b1;
        retire_i         = 1'b0;
        lookup_tid_i     = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Reset values
        chk("rst_req_valid", 32'(bus.req_valid_o), 32'd0);
        chk("rst_req_tid",   32'(bus.req_tid_o),   32'd0);
        chk("rst_req_addr",  32'(bus.req_addr_o),  32'd0);
        chk("rst_outst",     32'(outstanding_o),   32'd0);
        chk("rst_err",       32'(err_o),           32'd0);
        chk("rst_idle",      32'(idle_o),          32'd1);
        chk("rst_ar_ready",  32'(bus.ar_ready_o),  32'd1);
        lookup_tid_i = 4'd5;
        #1;
        chk("rst_lookup",    32'(lookup_id_o),     32'd0);

        // First request: id 3, addr 0x40
        bus.ar_valid_i = 1'b1;
        bus.ar_id_i    = 4'd3;
        bus.ar_addr_i  = 16'h0040;
        tick();
        bus.ar_valid_i = 1'b0;
        lookup_tid_i   = 4'd1;
        #1;
        chk("t1_req_valid", 32'(bus.req_valid_o), 32'd1);
        chk("t1_req_tid",   32'(bus.req_tid_o),   32'd1);
        chk("t1_req_addr",  32'(bus.req_addr_o),  32'h40);
        chk("t1_outst",     32'(outstanding_o),   32'd1);
        chk("t1_lookup",    32'(lookup_id_o),     32'd3);
        chk("t1_idle",      32'(idle_o),          32'd0);
        tick();
        chk("t1_drop_valid", 32'(bus.req_valid_o), 32'd0);

        // Back-to-back issue up to the limit
        do_reset();
        bus.ar_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ar_id_i   = ID_WIDTH'(i);
            bus.ar_addr_i = ADDR_WIDTH'(16'h0100 + i);
            #1;
            chk($sformatf("t2_ready_%0d", i), 32'(bus.ar_ready_o), 32'd1);
            tick();
            chk($sformatf("t2_tid_%0d", i),   32'(bus.req_tid_o),   32'(i + 1));
            chk($sformatf("t2_outst_%0d", i), 32'(outstanding_o),   32'(i + 1));
        end
        chk("t2_full_ready", 32'(bus.ar_ready_o), 32'd0);
        tick();
        chk("t2_full_outst", 32'(outstanding_o),   32'd4);
        chk("t2_full_valid", 32'(bus.req_valid_o), 32'd0);
        retire_i = 1'b1;
        #1;
        chk("t2_retire_same_cycle_ready", 32'(bus.ar_ready_o), 32'd0);
        tick();
        retire_i = 1'b0;
        #1;
        chk("t2_after_retire_outst", 32'(outstanding_o),  32'd3);
        chk("t2_after_retire_ready", 32'(bus.ar_ready_o), 32'd1);
        bus.ar_id_i   = 4'd9;
        bus.ar_addr_i = 16'h0200;
        tick();
        bus.ar_valid_i = 1'b0;
        lookup_tid_i   = 4'd3;
        #1;
        chk("t2_tid5",      32'(bus.req_tid_o),  32'd5);
        chk("t2_tid5_addr", 32'(bus.req_addr_o), 32'h0200);
        chk("t2_outst4",    32'(outstanding_o),  32'd4);
        chk("t2_lookup3",   32'(lookup_id_o),    32'd2);
        tick();

        // Back-pressure hold for 5 cycles
        retire_i = 1'b1;
        tick();
        tick();
        retire_i = 1'b0;
        chk("t3_pre_outst", 32'(outstanding_o), 32'd2);
        bus.req_ready_i = 1'b0;
        bus.ar_valid_i  = 1'b1;
        bus.ar_id_i     = 4'hA;
        bus.ar_addr_i   = 16'hBEEF;
        tick();
        bus.ar_id_i   = 4'hB;
        bus.ar_addr_i = 16'h1234;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("t3_hold_ready_%0d", c), 32'(bus.ar_ready_o),  32'd0);
            chk($sformatf("t3_hold_valid_%0d", c), 32'(bus.req_valid_o), 32'd1);
            chk($sformatf("t3_hold_tid_%0d", c),   32'(bus.req_tid_o),   32'd6);
            chk($sformatf("t3_hold_addr_%0d", c),  32'(bus.req_addr_o),  32'hBEEF);
            tick();
        end
        chk("t3_hold_outst", 32'(outstanding_o), 32'd3);
        bus.ar_valid_i  = 1'b0;
        bus.req_ready_i = 1'b1;
        tick();
        chk("t3_release_valid", 32'(bus.req_valid_o), 32'd0);
        chk("t3_release_outst", 32'(outstanding_o),   32'd3);

        // Accept and retire in the same cycle
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        chk("t4_pre_outst", 32'(outstanding_o), 32'd2);
        bus.ar_valid_i = 1'b1;
        bus.ar_id_i    = 4'd5;
        bus.ar_addr_i  = 16'h0055;
        retire_i       = 1'b1;
        #1;
        chk("t4_ready", 32'(bus.ar_ready_o), 32'd1);
        tick();
        bus.ar_valid_i = 1'b0;
        retire_i       = 1'b0;
        chk("t4_outst", 32'(outstanding_o), 32'd2);
        chk("t4_tid",   32'(bus.req_tid_o), 32'd7);
        tick();

        // tID wrap over 17 single transactions
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            bus.ar_valid_i = 1'b1;
            bus.ar_id_i    = (k == 17) ? 4'hE : ID_WIDTH'(k + 3);
            bus.ar_addr_i  = ADDR_WIDTH'(k * 16);
            if (k == 17) begin
                lookup_tid_i = 4'd1;
                #1;
                chk("t5_lookup1_old", 32'(lookup_id_o), 32'd4);
            end
            tick();
            bus.ar_valid_i = 1'b0;
            chk($sformatf("t5_tid_%0d", k), 32'(bus.req_tid_o), 32'(k % 16));
            retire_i = 1'b1;
            tick();
            retire_i = 1'b0;
        end
        chk("t5_lookup1_new", 32'(lookup_id_o), 32'hE);
        lookup_tid_i = 4'd0;
        #1;
        chk("t5_lookup0", 32'(lookup_id_o),   32'd3);
        chk("t5_outst",   32'(outstanding_o), 32'd0);
        chk("t5_idle",    32'(idle_o),        32'd1);

        // Retire underflow, then async reset while holding
        retire_i = 1'b1;
        tick();
        retire_i = 1'b0;
        chk("t6_err",   32'(err_o),         32'd1);
        chk("t6_outst", 32'(outstanding_o), 32'd0);
        tick();
        chk("t6_err_sticky", 32'(err_o), 32'd1);
        bus.req_ready_i = 1'b0;
        bus.ar_valid_i  = 1'b1;
        bus.ar_id_i     = 4'd7;
        bus.ar_addr_i   = 16'h7777;
        tick();
        bus.ar_valid_i = 1'b0;
        chk("t6_hold_valid", 32'(bus.req_valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.req_valid_o), 32'd0);
        chk("t6_async_err",   32'(err_o),           32'd0);
        chk("t6_async_outst", 32'(outstanding_o),   32'd0);
        chk("t6_async_tid",   32'(bus.req_tid_o),   32'd0);
        bus.req_ready_i = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_tid_issuer.md
Name: rob_tid_issuer

Overview:
- Front-end scheduler for the reorder buffer.
- Accepts AXI read-address requests and stamps each with a sequential transaction ID (tID) that matches the ROB's in-order retirement counter.
- Forwards the stamped request to the tag-compare stage, records the AXI ID per tID for the ROB's rid lookup, and throttles intake with an outstanding-transaction counter so neither ROB FIFO can overflow.

Parameters:
- ADDR_WIDTH, `AXI_ADDR_WIDTH, request address width.
- ID_WIDTH, `AXI_ID_WIDTH, AXI transaction ID width.
- TID_WIDTH, `TID_WIDTH, internal tID width; the ID table has 2^TID_WIDTH entries.
- MAX_OUTSTANDING, `FIFO_SIZE, maximum issued-but-unretired transactions. Legal range is 1..min(FIFO_SIZE, 2^TID_WIDTH-1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ar_valid_i  input  1  upstream read request valid.
- ar_ready_o  output  1  request accepted this cycle when ar_valid_i & ar_ready_o.
- ar_id_i  input  ID_WIDTH  AXI ID of request.
- ar_addr_i  input  ADDR_WIDTH  request address.
- req_valid_o  output  1  stamped request valid to tag compare.
- req_ready_i  input  1  tag compare accepts request.
- req_tid_o  output  TID_WIDTH  tID assigned to request.
- req_addr_o  output  ADDR_WIDTH  registered address.
- retire_i  input  1  one-cycle pulse per ROB retirement (ROB valid_o & ready_i).
- lookup_tid_i  input  TID_WIDTH  tID whose AXI ID the ROB needs.
- lookup_id_o  output  ID_WIDTH  combinational table read, table[lookup_tid_i].
- outstanding_o  output  clog2(MAX_OUTSTANDING+1)  current issued-unretired count.
- idle_o  output  1  high when state==S_IDLE and outstanding_o==0.
- err_o  output  1  sticky: retire_i seen with outstanding==0.

Behaviour:
- Reset (async, rst_n=0):
  - state=S_IDLE, next_tid=1 (matches ROB initial tID), outstanding=0.
  - req_valid_o=0, req_tid_o=0, req_addr_o=0, err_o=0.
  - All ID table entries are 0.
  - Reset mid-transaction drops any held request with no handshake completion.
- States:
  - S_IDLE: no request held.
  - S_HOLD: req_valid_o=1; req_tid_o and req_addr_o are stable until req_ready_i.
- ar_ready_o = (outstanding < MAX_OUTSTANDING) & (state==S_IDLE | req_ready_i). It is combinational, so back-to-back issue runs at one request per cycle.
- Accept (ar_valid_i & ar_ready_o), effects at the next edge:
  - req_tid_o <= next_tid; req_addr_o <= ar_addr_i; table[next_tid] <= ar_id_i.
  - next_tid <= next_tid+1, with natural modulo-2^TID_WIDTH wrap (2^W-1 -> 0), identical to the ROB counter.
  - State becomes S_HOLD.
- S_HOLD with req_ready_i and no accept: state returns to S_IDLE and req_valid_o drops next cycle. With req_ready_i and an accept: stay in S_HOLD with the new tID.
- Holding rule: while req_valid_o=1 and req_ready_i=0, all req_* outputs hold; ar_ready_o=0.
- Counter update: outstanding_n = outstanding + accept - (retire_i & outstanding!=0).
  - Simultaneous accept and retire leaves the count unchanged.
  - At outstanding==MAX_OUTSTANDING, a same-cycle retire does not raise ar_ready_o (ready uses the registered count).
- retire_i with outstanding==0: count stays 0 and err_o sets, held until reset.
- Lookup: lookup_id_o reflects a table write from the following cycle. Same-cycle write and read of the same tID returns the old value.
- Latency: accept to req_valid_o is 1 cycle. Accept to lookup visibility is 1 cycle.
- No combinational path from ar_valid_i to req_valid_o.

Test Plan (TID_WIDTH=4, MAX_OUTSTANDING=4):
- Reset, then ar_valid_i=1 with id=3, addr=0x40, req_ready_i=1 -> next cycle req_valid_o=1, req_tid_o=1, req_addr_o=0x40, outstanding_o=1; lookup_tid_i=1 gives lookup_id_o=3.
- Continuous ar_valid_i, req_ready_i=1, no retire -> tIDs 1,2,3,4 issued on consecutive cycles; ar_ready_o=0 at outstanding_o=4. One retire_i pulse -> ar_ready_o=1 next cycle and tID 5 issued.
- req_ready_i=0 for 5 cycles after accept -> req_valid_o, req_tid_o, req_addr_o stable for all 5; ar_ready_o=0; release gives exactly one handshake.
- Same cycle accept and retire_i at outstanding_o=2 -> outstanding_o remains 2.
- Issue and retire 16 transactions one at a time -> the 16th has req_tid_o=0 and the 17th has req_tid_o=1; table entry for tID 0 holds the 16th ID.
- retire_i with outstanding_o=0 -> err_o=1 sticky and outstanding_o=0. Assert rst_n=0 while in S_HOLD -> req_valid_o=0 and err_o=0 immediately, without waiting for a clock edge.
